// File: rtl/cic_decim_scheduler.sv
`timescale 1ns/1ps
// Multi-channel CIC decimation scheduler: per-channel rate counters feeding a
// round-robin arbiter for the single shared comb section, with overrun tracking.
module cic_decim_scheduler #(
   parameter int NCH      = 4,
   parameter int RW       = 8,
   parameter int DEF_RATE = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [RW-1:0]          rate_in,
   input  logic                   rate_load,
   input  logic [NCH-1:0]         in_valid,
   input  logic                   comb_ready,
   input  logic                   clear_ovr,
   output logic                   comb_en,
   output logic [$clog2(NCH)-1:0] comb_ch,
   output logic [NCH-1:0]         pending,
   output logic [NCH-1:0]         overrun,
   output logic                   busy
);

   localparam int CW = $clog2(NCH);

   logic [RW-1:0]  rate_r;
   logic [RW-1:0]  cnt_r [NCH];
   logic [NCH-1:0] pending_r;
   logic [NCH-1:0] overrun_r;
   logic           comb_en_r;
   logic [CW-1:0]  comb_ch_r;
   logic [CW-1:0]  last_grant_r;
   logic           busy_r;

   logic [RW-1:0]  cnt_nxt_s [NCH];
   logic [NCH-1:0] event_s;
   logic [NCH-1:0] grant_s;
   logic           grant_vld_s;
   logic [CW-1:0]  grant_idx_s;
   logic [NCH-1:0] ovr_set_s;
   logic [NCH-1:0] pending_nxt_s;
   logic [NCH-1:0] overrun_nxt_s;
   logic [RW-1:0]  load_rate_s;

   // Per-channel sample counters and decimation event detection.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         event_s[i]   = 1'b0;
         cnt_nxt_s[i] = cnt_r[i];
         if (in_valid[i]) begin
            if (cnt_r[i] == (rate_r - RW'(1))) begin
               cnt_nxt_s[i] = {RW{1'b0}};
               event_s[i]   = 1'b1;
            end else begin
               cnt_nxt_s[i] = cnt_r[i] + RW'(1);
            end
         end else begin
            cnt_nxt_s[i] = cnt_r[i];
         end
      end
   end

   // Round-robin search starting one past the last granted channel.
   always_comb begin : arb
      int cand;
      grant_s     = {NCH{1'b0}};
      grant_vld_s = 1'b0;
      grant_idx_s = last_grant_r;
      cand        = 0;
      for (int k = 1; k <= NCH; k++) begin
         cand = int'(last_grant_r) + k;
         if (cand >= NCH) begin
            cand = cand - NCH;
         end else begin
            cand = cand;
         end
         if (comb_ready && !grant_vld_s && pending_r[CW'(cand)]) begin
            grant_vld_s          = 1'b1;
            grant_idx_s          = CW'(cand);
            grant_s[CW'(cand)]   = 1'b1;
         end else begin
            grant_vld_s = grant_vld_s;
         end
      end
   end

   // Pending/overrun next state; a granted channel may re-arm in the same cycle.
   always_comb begin
      ovr_set_s     = event_s & pending_r & ~grant_s;
      pending_nxt_s = (pending_r & ~grant_s) | event_s;
      overrun_nxt_s = (overrun_r & ~{NCH{clear_ovr}}) | ovr_set_s;
      if (rate_in == {RW{1'b0}}) begin
         load_rate_s = RW'(1);
      end else begin
         load_rate_s = rate_in;
      end
   end

   // State update: reset, then rate reload, then normal scheduling.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rate_r       <= RW'(DEF_RATE);
         for (int i = 0; i < NCH; i++) begin
            cnt_r[i] <= {RW{1'b0}};
         end
         pending_r    <= {NCH{1'b0}};
         overrun_r    <= {NCH{1'b0}};
         comb_en_r    <= 1'b0;
         comb_ch_r    <= {CW{1'b0}};
         last_grant_r <= CW'(NCH - 1);
         busy_r       <= 1'b0;
      end else if (rate_load) begin
         rate_r       <= load_rate_s;
         for (int i = 0; i < NCH; i++) begin
            cnt_r[i] <= {RW{1'b0}};
         end
         pending_r    <= {NCH{1'b0}};
         overrun_r    <= overrun_r;
         comb_en_r    <= 1'b0;
         comb_ch_r    <= comb_ch_r;
         last_grant_r <= last_grant_r;
         busy_r       <= 1'b0;
      end else begin
         rate_r       <= rate_r;
         for (int i = 0; i < NCH; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
         pending_r    <= pending_nxt_s;
         overrun_r    <= overrun_nxt_s;
         comb_en_r    <= grant_vld_s;
         busy_r       <= |pending_nxt_s;
         if (grant_vld_s) begin
            comb_ch_r    <= grant_idx_s;
            last_grant_r <= grant_idx_s;
         end else begin
            comb_ch_r    <= comb_ch_r;
            last_grant_r <= last_grant_r;
         end
      end
   end

   assign comb_en = comb_en_r;
   assign comb_ch = comb_ch_r;
   assign pending = pending_r;
   assign overrun = overrun_r;
   assign busy    = busy_r;

endmodule
